// File: rtl/renderizador_pkg.sv
// Shared widths, default colours and object-priority helpers for the renderizador pixel stage.
package renderizador_pkg;

  localparam int unsigned COR_W   = 8;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned RGB_W   = 3 * COR_W;

  localparam logic [RGB_W-1:0] COR_FUNDO_DEF   = 24'h000000;
  localparam logic [RGB_W-1:0] COR_ALIADA_DEF  = 24'h00FF00;
  localparam logic [RGB_W-1:0] COR_INIMIGA_DEF = 24'hFF0000;
  localparam logic [RGB_W-1:0] COR_NAVE_DEF    = 24'hFFFFFF;

  // Which object owns the pixel, lowest to highest precedence
  typedef enum logic [1:0] {
    PRI_FUNDO   = 2'd0,
    PRI_NAVE    = 2'd1,
    PRI_INIMIGA = 2'd2,
    PRI_ALIADA  = 2'd3
  } prioridade_t;

  function automatic prioridade_t resolve_prioridade(input logic aliada,
                                                     input logic inimiga,
                                                     input logic nave);
    if (aliada)  return PRI_ALIADA;
    if (inimiga) return PRI_INIMIGA;
    if (nave)    return PRI_NAVE;
    return PRI_FUNDO;
  endfunction

  // Halve every channel of a packed {R,G,B} colour
  function automatic logic [RGB_W-1:0] meia_intensidade(input logic [RGB_W-1:0] cor);
    return {1'b0, cor[23:17], 1'b0, cor[15:9], 1'b0, cor[7:1]};
  endfunction

endpackage

// File: rtl/renderizador_if.sv
// Pixel stream bus: scan coordinate in, colour out towards the VGA DAC.
interface renderizador_if;

  logic [renderizador_pkg::COORD_W-1:0] pixel_x;
  logic [renderizador_pkg::COORD_W-1:0] pixel_y;
  logic                                 pixel_valid;
  logic [renderizador_pkg::COR_W-1:0]   vga_r;
  logic [renderizador_pkg::COR_W-1:0]   vga_g;
  logic [renderizador_pkg::COR_W-1:0]   vga_b;
  logic                                 cor_valida;

  // Scan generator side
  modport master (
    output pixel_x, pixel_y, pixel_valid,
    input  vga_r, vga_g, vga_b, cor_valida
  );

  // Renderer side
  modport slave (
    input  pixel_x, pixel_y, pixel_valid,
    output vga_r, vga_g, vga_b, cor_valida
  );

endinterface

// File: rtl/renderizador_teste_circulo.sv
// Pipelined circle hit test: stage 1 registers the signed offsets, stage 2
// (combinational here, registered by the parent) compares dx^2+dy^2 to raio^2.
module teste_circulo
  import renderizador_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] xc,
  input  logic [COORD_W-1:0] yc,
  input  logic [COORD_W-1:0] raio,
  input  logic               valid,
  output logic               hit
);

  localparam int unsigned SQ_W  = 2 * COORD_W + 1;
  localparam int unsigned SUM_W = SQ_W + 1;

  logic signed [COORD_W:0] dx_q;
  logic signed [COORD_W:0] dy_q;
  logic [COORD_W-1:0]      raio_q;
  logic                    valid_q;

  logic [COORD_W:0] adx;
  logic [COORD_W:0] ady;
  logic [SQ_W-1:0]  dx2;
  logic [SQ_W-1:0]  dy2;
  logic [SUM_W-1:0] soma;
  logic [SUM_W-1:0] r2;

  // Stage 1: offsets from the centre; raio travels with the pixel so a
  // shadow update between the stages cannot mix two frames' geometry
  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q    <= '0;
      dy_q    <= '0;
      raio_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dx_q    <= {1'b0, px} - {1'b0, xc};
      dy_q    <= {1'b0, py} - {1'b0, yc};
      raio_q  <= raio;
      valid_q <= valid;
    end
  end

  // Stage 2: squared distance against squared radius, zero radius never hits
  always_comb begin
    adx  = dx_q[COORD_W] ? -dx_q : dx_q;
    ady  = dy_q[COORD_W] ? -dy_q : dy_q;
    dx2  = SQ_W'(adx) * SQ_W'(adx);
    dy2  = SQ_W'(ady) * SQ_W'(ady);
    soma = SUM_W'(dx2) + SUM_W'(dy2);
    r2   = SUM_W'(raio_q) * SUM_W'(raio_q);
    hit  = valid_q && (raio_q != '0) && (soma <= r2);
  end

endmodule

// File: rtl/renderizador.sv
// Pixel-colour stage: per-frame geometry shadowing, circle/rectangle hit tests,
// priority resolution and pause blink, 2-cycle latency to the VGA pins.
module renderizador
  import renderizador_pkg::*;
#(
  parameter logic [RGB_W-1:0] COR_FUNDO   = COR_FUNDO_DEF,
  parameter logic [RGB_W-1:0] COR_ALIADA  = COR_ALIADA_DEF,
  parameter logic [RGB_W-1:0] COR_INIMIGA = COR_INIMIGA_DEF,
  parameter logic [RGB_W-1:0] COR_NAVE    = COR_NAVE_DEF,
  parameter int unsigned      BLINK_BIT   = 4
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  renderizador_if.slave      vid,
  input  logic               frame_start,
  input  logic               pausa,
  input  logic [COORD_W-1:0] x_bola_aliada,
  input  logic [COORD_W-1:0] y_bola_aliada,
  input  logic [COORD_W-1:0] raio_bola_aliada,
  input  logic [COORD_W-1:0] x_bola_inimiga,
  input  logic [COORD_W-1:0] y_bola_inimiga,
  input  logic [COORD_W-1:0] raio_bola_inimiga,
  input  logic [COORD_W-1:0] x_nave,
  input  logic [COORD_W-1:0] y_nave,
  input  logic [COORD_W-1:0] largura_nave,
  input  logic [COORD_W-1:0] altura_nave
);

  logic [COORD_W-1:0] sh_x_aliada, sh_y_aliada, sh_raio_aliada;
  logic [COORD_W-1:0] sh_x_inimiga, sh_y_inimiga, sh_raio_inimiga;
  logic [COORD_W-1:0] sh_x_nave, sh_y_nave, sh_largura, sh_altura;
  logic               sh_pausa;
  logic [7:0]         frame_cnt;

  logic [COORD_W:0]   nave_x_fim, nave_y_fim;
  logic               nave_d, nave_q, valid_q;
  logic               hit_aliada, hit_inimiga;
  prioridade_t        pri;
  logic [RGB_W-1:0]   cor;

  // Shadow geometry and pause state once per frame so objects never tear
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sh_x_aliada     <= '0;
      sh_y_aliada     <= '0;
      sh_raio_aliada  <= '0;
      sh_x_inimiga    <= '0;
      sh_y_inimiga    <= '0;
      sh_raio_inimiga <= '0;
      sh_x_nave       <= '0;
      sh_y_nave       <= '0;
      sh_largura      <= '0;
      sh_altura       <= '0;
      sh_pausa        <= 1'b0;
      frame_cnt       <= '0;
    end else if (frame_start) begin
      sh_x_aliada     <= x_bola_aliada;
      sh_y_aliada     <= y_bola_aliada;
      sh_raio_aliada  <= raio_bola_aliada;
      sh_x_inimiga    <= x_bola_inimiga;
      sh_y_inimiga    <= y_bola_inimiga;
      sh_raio_inimiga <= raio_bola_inimiga;
      sh_x_nave       <= x_nave;
      sh_y_nave       <= y_nave;
      sh_largura      <= largura_nave;
      sh_altura       <= altura_nave;
      sh_pausa        <= pausa;
      frame_cnt       <= frame_cnt + 8'd1;
    end
  end

  teste_circulo u_aliada (
    .clk   (CLOCK_50),
    .reset (reset),
    .px    (vid.pixel_x),
    .py    (vid.pixel_y),
    .xc    (sh_x_aliada),
    .yc    (sh_y_aliada),
    .raio  (sh_raio_aliada),
    .valid (vid.pixel_valid),
    .hit   (hit_aliada)
  );

  teste_circulo u_inimiga (
    .clk   (CLOCK_50),
    .reset (reset),
    .px    (vid.pixel_x),
    .py    (vid.pixel_y),
    .xc    (sh_x_inimiga),
    .yc    (sh_y_inimiga),
    .raio  (sh_raio_inimiga),
    .valid (vid.pixel_valid),
    .hit   (hit_inimiga)
  );

  // Ship rectangle test with 11-bit far edges so x+largura never wraps
  always_comb begin
    nave_x_fim = {1'b0, sh_x_nave} + {1'b0, sh_largura};
    nave_y_fim = {1'b0, sh_y_nave} + {1'b0, sh_altura};
    nave_d     = (vid.pixel_x >= sh_x_nave) && ({1'b0, vid.pixel_x} < nave_x_fim) &&
                 (vid.pixel_y >= sh_y_nave) && ({1'b0, vid.pixel_y} < nave_y_fim);
  end

  // Stage 1: rectangle result and valid flag, aligned with the circle offsets
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      nave_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      nave_q  <= nave_d;
      valid_q <= vid.pixel_valid;
    end
  end

  // Resolve object priority and apply half intensity during the paused blink phase
  always_comb begin
    pri = resolve_prioridade(hit_aliada, hit_inimiga, nave_q);
    cor = COR_FUNDO;
    unique case (pri)
      PRI_ALIADA:  cor = COR_ALIADA;
      PRI_INIMIGA: cor = COR_INIMIGA;
      PRI_NAVE:    cor = COR_NAVE;
      PRI_FUNDO:   cor = COR_FUNDO;
    endcase
    if (sh_pausa && frame_cnt[BLINK_BIT] && (pri != PRI_FUNDO))
      cor = meia_intensidade(cor);
  end

  // Stage 2: registered colour towards the DAC, black while blanking
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      vid.vga_r      <= '0;
      vid.vga_g      <= '0;
      vid.vga_b      <= '0;
      vid.cor_valida <= 1'b0;
    end else begin
      vid.vga_r      <= valid_q ? cor[23:16] : '0;
      vid.vga_g      <= valid_q ? cor[15:8]  : '0;
      vid.vga_b      <= valid_q ? cor[7:0]   : '0;
      vid.cor_valida <= valid_q;
    end
  end

endmodule

// File: tb/tb_renderizador.sv
// Bench for renderizador: table-driven pixel vectors plus hand-written frame,
// pause and reset sequences, checked through a 2-deep expectation queue.
module tb_renderizador;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       pausa;
  logic [9:0] x_bola_aliada, y_bola_aliada, raio_bola_aliada;
  logic [9:0] x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga;
  logic [9:0] x_nave, y_nave, largura_nave, altura_nave;

  renderizador_if vid ();

  renderizador #(
    .BLINK_BIT (4)
  ) dut (
    .CLOCK_50          (CLOCK_50),
    .reset             (reset),
    .vid               (vid),
    .frame_start       (frame_start),
    .pausa             (pausa),
    .x_bola_aliada     (x_bola_aliada),
    .y_bola_aliada     (y_bola_aliada),
    .raio_bola_aliada  (raio_bola_aliada),
    .x_bola_inimiga    (x_bola_inimiga),
    .y_bola_inimiga    (y_bola_inimiga),
    .raio_bola_inimiga (raio_bola_inimiga),
    .x_nave            (x_nave),
    .y_nave            (y_nave),
    .largura_nave      (largura_nave),
    .altura_nave       (altura_nave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        v;
    logic [23:0] rgb;
    logic        cv;
    string       nome;
  } vec_t;

  typedef struct {
    bit          chk;
    logic [23:0] rgb;
    logic        cv;
    string       nome;
  } exp_t;

  exp_t       sb[$];
  vec_t       tab[$];
  int         erros  = 0;
  int         checks = 0;
  logic [7:0] fcnt   = '0;

  function automatic vec_t mk(input logic [9:0] x, input logic [9:0] y, input logic v,
                              input logic [23:0] rgb, input logic cv, input string nome);
    vec_t t;
    t.x = x; t.y = y; t.v = v; t.rgb = rgb; t.cv = cv; t.nome = nome;
    return t;
  endfunction

  task automatic compara(input string nome, input logic [23:0] rgb, input logic cv);
    logic [23:0] got;
    got = {vid.vga_r, vid.vga_g, vid.vga_b};
    checks++;
    if (got !== rgb || vid.cor_valida !== cv) begin
      erros++;
      $display("FAIL %s: got rgb=%06h cor_valida=%0b, expected rgb=%06h cor_valida=%0b",
               nome, got, vid.cor_valida, rgb, cv);
    end
  endtask

  // Drive one cycle; the output seen after this edge belongs to the previous cycle's input
  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic v, input logic fs,
                      input bit chk, input logic [23:0] rgb, input logic cv, input string nome);
    exp_t e;
    vid.pixel_x     = x;
    vid.pixel_y     = y;
    vid.pixel_valid = v;
    frame_start     = fs;
    e.chk = chk; e.rgb = rgb; e.cv = cv; e.nome = nome;
    sb.push_back(e);
    @(posedge CLOCK_50);
    #1;
    frame_start = 1'b0;
    if (fs) fcnt = fcnt + 8'd1;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      if (e.chk) compara(e.nome, e.rgb, e.cv);
    end
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [23:0] rgb,
                     input string nome);
    step(x, y, 1'b1, 1'b0, 1'b1, rgb, 1'b1, nome);
  endtask

  task automatic idle();
    step('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, "idle");
  endtask

  task automatic frame(input logic p);
    pausa = p;
    step('0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0, "frame");
  endtask

  task automatic set_geo(input logic [9:0] ax, input logic [9:0] ay, input logic [9:0] ar,
                         input logic [9:0] ex, input logic [9:0] ey, input logic [9:0] er,
                         input logic [9:0] sx, input logic [9:0] sy,
                         input logic [9:0] sw, input logic [9:0] sh);
    x_bola_aliada  = ax; y_bola_aliada  = ay; raio_bola_aliada  = ar;
    x_bola_inimiga = ex; y_bola_inimiga = ey; raio_bola_inimiga = er;
    x_nave = sx; y_nave = sy; largura_nave = sw; altura_nave = sh;
  endtask

  task automatic run_tab();
    foreach (tab[i])
      step(tab[i].x, tab[i].y, tab[i].v, 1'b0, 1'b1, tab[i].rgb, tab[i].cv, tab[i].nome);
    tab.delete();
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    pausa = 1'b0;
    vid.pixel_x = '0;
    vid.pixel_y = '0;
    vid.pixel_valid = 1'b0;
    set_geo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge CLOCK_50);
    #1;
    compara("reset_state", 24'h000000, 1'b0);
    reset = 1'b0;
    fcnt = '0;

    // Frame A: ally circle boundaries, zero-radius enemy, ship edges
    set_geo(100, 100, 5, 50, 50, 0, 195, 195, 20, 20);
    frame(1'b0);
    tab.push_back(mk(103, 104, 1, 24'h00FF00, 1, "ally_inside_25"));
    tab.push_back(mk(104, 104, 1, 24'h000000, 1, "ally_outside_32"));
    tab.push_back(mk(100,  95, 1, 24'h00FF00, 1, "ally_edge_dy_neg"));
    tab.push_back(mk(100,  94, 1, 24'h000000, 1, "ally_past_edge"));
    tab.push_back(mk( 50,  50, 1, 24'h000000, 1, "enemy_r0"));
    tab.push_back(mk(212, 212, 1, 24'hFFFFFF, 1, "ship_inside"));
    tab.push_back(mk(195, 195, 1, 24'hFFFFFF, 1, "ship_top_left"));
    tab.push_back(mk(214, 214, 1, 24'hFFFFFF, 1, "ship_bottom_right"));
    tab.push_back(mk(215, 200, 1, 24'h000000, 1, "ship_x_exclusive"));
    tab.push_back(mk(200, 215, 1, 24'h000000, 1, "ship_y_exclusive"));
    tab.push_back(mk(194, 200, 1, 24'h000000, 1, "ship_left_of"));
    tab.push_back(mk(200, 200, 0, 24'h000000, 0, "blank_over_ship_a"));
    run_tab();

    // Frame B: ally over ship, enemy with radius 1
    set_geo(200, 200, 10, 50, 50, 1, 195, 195, 20, 20);
    frame(1'b0);
    tab.push_back(mk(200, 200, 1, 24'h00FF00, 1, "ally_over_ship"));
    tab.push_back(mk(210, 200, 1, 24'h00FF00, 1, "ally_edge_over_ship"));
    tab.push_back(mk(212, 212, 1, 24'hFFFFFF, 1, "ship_only"));
    tab.push_back(mk(215, 200, 1, 24'h000000, 1, "ship_exclusive_b"));
    tab.push_back(mk( 51,  50, 1, 24'hFF0000, 1, "enemy_r1_edge"));
    tab.push_back(mk( 50,  51, 1, 24'hFF0000, 1, "enemy_r1_edge_y"));
    tab.push_back(mk( 52,  50, 1, 24'h000000, 1, "enemy_r1_outside"));
    run_tab();

    // Frame C: ally beats enemy beats ship
    set_geo(200, 200, 3, 200, 200, 10, 195, 195, 20, 20);
    frame(1'b0);
    tab.push_back(mk(200, 200, 1, 24'h00FF00, 1, "prio_ally_over_enemy"));
    tab.push_back(mk(203, 200, 1, 24'h00FF00, 1, "prio_ally_edge"));
    tab.push_back(mk(208, 200, 1, 24'hFF0000, 1, "prio_enemy_over_ship"));
    tab.push_back(mk(212, 212, 1, 24'hFFFFFF, 1, "prio_ship_only"));
    run_tab();

    // Geometry changes only take effect at frame_start, even one arriving with a pixel
    set_geo(100, 100, 5, 50, 50, 1, 195, 195, 20, 20);
    frame(1'b0);
    pix(100, 100, 24'h00FF00, "ally_before_move");
    x_bola_aliada = 300;
    pix(100, 100, 24'h00FF00, "ally_shadowed");
    step(100, 100, 1'b1, 1'b1, 1'b1, 24'h00FF00, 1'b1, "fs_with_pixel_old");
    pix(100, 100, 24'h000000, "ally_moved_away");
    pix(300, 100, 24'h00FF00, "ally_moved_here");

    // Pause blink: pausa is only honoured once latched by a frame_start
    while (fcnt[4] !== 1'b1) frame(1'b0);
    pausa = 1'b1;
    pix(205, 205, 24'hFFFFFF, "pause_unlatched");
    while (fcnt[4] !== 1'b0) frame(1'b1);
    while (fcnt[4] !== 1'b1) frame(1'b1);
    pix(205, 205, 24'h7F7F7F, "blink_ship");
    pix(300, 100, 24'h007F00, "blink_ally");
    pix( 51,  50, 24'h7F0000, "blink_enemy");
    pix(400, 400, 24'h000000, "blink_background");
    while (fcnt[4] !== 1'b0) frame(1'b1);
    pix(205, 205, 24'hFFFFFF, "blink_off_phase");

    // Blanking and mid-stream reset
    frame(1'b0);
    step(205, 205, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, "blank_over_ship");
    pix(205, 205, 24'hFFFFFF, "pre_reset_ship");
    pix(206, 206, 24'hFFFFFF, "pre_reset_ship2");
    sb.delete();
    reset = 1'b1;
    vid.pixel_x = 205;
    vid.pixel_y = 205;
    vid.pixel_valid = 1'b1;
    @(posedge CLOCK_50);
    #1;
    compara("reset_mid_stream", 24'h000000, 1'b0);
    reset = 1'b0;
    fcnt = '0;
    pix(205, 205, 24'h000000, "no_ship_after_reset");
    pix(205, 205, 24'h000000, "no_ship_after_reset2");
    frame(1'b0);
    pix(205, 205, 24'hFFFFFF, "ship_after_frame");
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule
